tri_state_bus_rx: RTL and testbench

TRI_STATE_BUS_RX -- requirements
Module: tri_state_bus_rx

---
 rtl/tri_state_bus_pkg.sv | 21 ++
 rtl/tri_state_bus_sync.sv | 22 ++
 rtl/tri_state_bus_rx.sv | 177 +++++++++++++++++
 tb/tb_tri_state_bus_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tri_state_bus_pkg.sv
// Shared types and constants for the single-wire bus receiver.
// TRI_STATE_BUS_RX_PARITY_EN adds the PARITY state to the FSM encoding.
package tri_state_bus_pkg;

  localparam int DEF_DATA_W = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef TRI_STATE_BUS_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

endpackage

// File: rtl/tri_state_bus_sync.sv
// Two-flop synchronizer for the asynchronous bus line; reset value 1 (idle).
// Latency 2 cycles, no backpressure.
module tri_state_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tri_state_bus_rx.sv
// Oversampling receiver for a pulled-up single-wire bus: start, DATA_W bits LSB first, stop.
// TRI_STATE_BUS_RX_PARITY_EN adds an even-parity bit before stop; overrun pulses when a frame finds rx_valid still pending.
import tri_state_bus_pkg::*;

module tri_state_bus_rx #(
  parameter int BIT_CYCLES = 4,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int BW = $clog2(DATA_W + 1);

  state_t            state, state_nxt;
  logic              line;
  logic              prev;
  logic [1:0]        settle;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              fin_good;
  logic              fin_bad;
  logic              fall;
  logic              tick;
  logic              last_bit;
  logic              stop_ok;
`ifdef TRI_STATE_BUS_RX_PARITY_EN
  logic              par_bad;
`endif

  tri_state_bus_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus_in),
    .q   (line)
  );

  assign fall     = prev & ~line;
  assign tick     = (cnt == CW'(1));
  assign last_bit = (bit_cnt == BW'(DATA_W - 1));
`ifdef TRI_STATE_BUS_RX_PARITY_EN
  assign stop_ok  = (line == STOP_BIT) && !par_bad;
`else
  assign stop_ok  = (line == STOP_BIT);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fall) state_nxt = ST_START;
      ST_START: if (tick) state_nxt = (line == START_BIT) ? ST_DATA : ST_IDLE;
      ST_DATA: begin
        if (tick && last_bit) begin
`ifdef TRI_STATE_BUS_RX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef TRI_STATE_BUS_RX_PARITY_EN
      ST_PARITY: if (tick) state_nxt = ST_STOP;
`endif
      ST_STOP:      if (tick) state_nxt = (line == STOP_BIT) ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (line) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  // The synchronizer resets to 1, so prev stays 0 until those reset values have flushed out;
  // a line held low through reset then cannot look like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle <= 2'b00;
      prev   <= 1'b0;
    end else begin
      settle <= {settle[0], 1'b1};
      prev   <= settle[1] ? line : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      fin_good <= 1'b0;
      fin_bad  <= 1'b0;
`ifdef TRI_STATE_BUS_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      fin_good <= 1'b0;
      fin_bad  <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt     <= CW'(BIT_CYCLES / 2);
          bit_cnt <= '0;
`ifdef TRI_STATE_BUS_RX_PARITY_EN
          par_bad <= 1'b0;
`endif
        end
        ST_START: cnt <= tick ? CW'(BIT_CYCLES) : cnt - CW'(1);
        ST_DATA: begin
          if (tick) begin
            shreg   <= {line, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
            cnt     <= CW'(BIT_CYCLES);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`ifdef TRI_STATE_BUS_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            par_bad <= line ^ (^shreg);
            cnt     <= CW'(BIT_CYCLES);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            fin_good <= stop_ok;
            fin_bad  <= !stop_ok;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

  // A completing frame may reuse the slot the consumer is draining this same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fin_bad;
      overrun   <= 1'b0;
      if (fin_good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tri_state_bus_rx.sv
// Directed bench: table of whole frames plus sequences for reset, glitch and stuck-low stop.
module tb_tri_state_bus_rx;

  localparam int BC = 4;
`ifdef TRI_STATE_BUS_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LAT = 2 + BC / 2 + (8 + 1 + PAR) * BC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       bus_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tri_state_bus_rx #(.BIT_CYCLES(BC), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_in    (bus_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic       rdy;
    logic       rdy_end;
    logic       v40;
    logic       v41;
    logic [7:0] d41;
    logic       e41;
    logic       o41;
    logic       v42;
  } vec_t;

  vec_t tbl [0:6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bus at the stop-bit level; the caller restores idle.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_ok);
    bus_in = 1'b0;
    step(BC);
    for (int i = 0; i < 8; i++) begin
      bus_in = data[i];
      step(BC);
    end
    if (PAR != 0) begin
      bus_in = par_ok ? (^data) : ~(^data);
      step(BC);
    end
    bus_in = stop;
    step(BC);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus_in = 1'b1; rx_ready = 1'b0;
    step(3);
    check("rst_data",  rx_data,   0);
    check("rst_valid", rx_valid,  0);
    check("rst_err",   frame_err, 0);
    check("rst_ovr",   overrun,   0);
    check("rst_busy",  busy,      0);

    // line held low across reset release must not start a frame
    bus_in = 1'b0;
    step(2);
    rst = 1'b0;
    step(12);
    check("lowrst_busy", busy, 0);
    bus_in = 1'b1;
    step(6);
    check("lowrst_busy_after_high", busy, 0);
    check("lowrst_valid", rx_valid, 0);

    // two-cycle glitch enters START then falls back to IDLE
    bus_in = 1'b0;
    step(2);
    bus_in = 1'b1;
    step(1);
    check("glitch_busy_start", busy, 1);
    step(2);
    check("glitch_busy_idle", busy, 0);
    check("glitch_valid", rx_valid, 0);
    check("glitch_err", frame_err, 0);
    step(4);

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < 7; k++) begin
      rx_ready = tbl[k].rdy;
      send_frame(tbl[k].data, tbl[k].stop, 1'b1);
      step(1);
      check($sformatf("v%0d_pre_valid", k), rx_valid,  tbl[k].v40);
      check($sformatf("v%0d_pre_err", k),   frame_err, 0);
      check($sformatf("v%0d_pre_ovr", k),   overrun,   0);
      rx_ready = tbl[k].rdy_end;
      step(1);
      check($sformatf("v%0d_valid", k), rx_valid,  tbl[k].v41);
      check($sformatf("v%0d_data", k),  rx_data,   tbl[k].d41);
      check($sformatf("v%0d_err", k),   frame_err, tbl[k].e41);
      check($sformatf("v%0d_ovr", k),   overrun,   tbl[k].o41);
      step(1);
      check($sformatf("v%0d_post_valid", k), rx_valid,  tbl[k].v42);
      check($sformatf("v%0d_post_data", k),  rx_data,   tbl[k].d41);
      check($sformatf("v%0d_post_err", k),   frame_err, 0);
      check($sformatf("v%0d_post_ovr", k),   overrun,   0);
      bus_in = 1'b1;
      step(6);
    end

    // bad stop bit with the line stuck low: busy until it returns high
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b0, 1'b1);
    step(2);
    check("stuck_err", frame_err, 1);
    check("stuck_valid", rx_valid, 0);
    step(8);
    check("stuck_busy", busy, 1);
    check("stuck_err_once", frame_err, 0);
    bus_in = 1'b1;
    step(2);
    check("stuck_busy_sync", busy, 1);
    step(1);
    check("stuck_busy_released", busy, 0);
    step(4);

    // reset after data bit 3 of 0xF0 drops the partial frame
    bus_in = 1'b0;
    step(BC);
    for (int i = 0; i < 4; i++) begin
      bus_in = 1'b0;
      step(BC);
    end
    rst = 1'b1; bus_in = 1'b1;
    step(2);
    rst = 1'b0;
    step(4);
    check("midrst_data",  rx_data,   0);
    check("midrst_valid", rx_valid,  0);
    check("midrst_err",   frame_err, 0);
    check("midrst_ovr",   overrun,   0);
    check("midrst_busy",  busy,      0);
    send_frame(8'h0F, 1'b1, 1'b1);
    bus_in = 1'b1;
    step(1);
    check("midrst_next_pre_valid", rx_valid, 0);
    step(1);
    check("midrst_next_valid", rx_valid, 1);
    check("midrst_next_data",  rx_data,  8'h0F);
    step(6);

    if (PAR != 0) begin
      send_frame(8'h07, 1'b1, 1'b1);
      bus_in = 1'b1;
      step(1);
      check("par_good_pre_valid", rx_valid, 0);
      step(1);
      check("par_good_valid", rx_valid, 1);
      check("par_good_data",  rx_data,  8'h07);
      step(6);
      send_frame(8'h07, 1'b1, 1'b0);
      bus_in = 1'b1;
      step(2);
      check("par_bad_err",   frame_err, 1);
      check("par_bad_valid", rx_valid,  0);
      step(4);
      check("par_bad_busy",  busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
